// File: rtl/answer_arbiter_pkg.sv
// Shared definitions for the answer arbiter: FSM state encoding, defaults and a width helper.
package answer_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } arb_state_t;

  localparam int DEFAULT_N_PLAYERS       = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 20;
  localparam int DEFAULT_TIME_W          = 6;

  // A single-player configuration still needs a 1-bit winner_id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/answer_arbiter_debounce.sv
// One button channel: 2-FF synchroniser, counting debouncer and a registered rising-edge pulse.
module btn_debounce
  import answer_arbiter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
      rise    <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      rise    <= 1'b0;
      if (sync_q2 != stable) begin
        // Flip once the input has disagreed for DEBOUNCE_CYCLES consecutive cycles.
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable <= sync_q2;
          rise   <= sync_q2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/answer_arbiter.sv
// Answer arbiter: debounced buzz-in, timed answer window, first-press lock and false-start tracking.
module answer_arbiter
  import answer_arbiter_pkg::*;
#(
  parameter int N_PLAYERS       = DEFAULT_N_PLAYERS,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TIME_W          = DEFAULT_TIME_W,
  localparam int PID_W          = id_width(N_PLAYERS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PLAYERS-1:0] press,
  input  logic [N_PLAYERS-1:0] players_en,
  input  logic                 arm,
  input  logic                 clear,
  input  logic                 sec_tick,
  input  logic [TIME_W-1:0]    time_limit,
  output logic                 winner_valid,
  output logic [PID_W-1:0]     winner_id,
  output logic [N_PLAYERS-1:0] winner_onehot,
  output logic                 timeout,
  output logic [TIME_W-1:0]    remaining,
  output logic [N_PLAYERS-1:0] false_start,
  output logic                 buzz_req
);

  arb_state_t           state;
  logic [N_PLAYERS-1:0] rise;
  logic [N_PLAYERS-1:0] elig_edge;
  logic                 win_any;
  logic [PID_W-1:0]     win_idx;

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk  (clk),
      .rst  (rst),
      .raw  (press[g]),
      .rise (rise[g])
    );
  end

  assign elig_edge = rise & players_en & ~false_start;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    win_any = |elig_edge;
    win_idx = '0;
    // Scan downward so the lowest simultaneous index is the last one written.
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (elig_edge[i]) win_idx = PID_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      winner_valid  <= 1'b0;
      winner_id     <= '0;
      winner_onehot <= '0;
      timeout       <= 1'b0;
      remaining     <= '0;
      false_start   <= '0;
      buzz_req      <= 1'b0;
    end else begin
      buzz_req <= 1'b0;
      if (clear) begin
        state         <= ST_IDLE;
        winner_valid  <= 1'b0;
        winner_id     <= '0;
        winner_onehot <= '0;
        timeout       <= 1'b0;
        remaining     <= '0;
        false_start   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            false_start <= false_start | (rise & players_en);
            if (arm) begin
              remaining <= time_limit;
              if (time_limit == '0) begin
                state    <= ST_TIMEOUT;
                timeout  <= 1'b1;
                buzz_req <= 1'b1;
              end else begin
                state <= ST_ARMED;
              end
            end
          end
          ST_ARMED: begin
            // A buzz-in beats a coincident final tick, so remaining is left untouched here.
            if (win_any) begin
              state         <= ST_LOCKED;
              winner_valid  <= 1'b1;
              winner_id     <= win_idx;
              winner_onehot <= N_PLAYERS'(1) << win_idx;
              buzz_req      <= 1'b1;
            end else if (sec_tick) begin
              remaining <= remaining - TIME_W'(1);
              if (remaining == TIME_W'(1)) begin
                state    <= ST_TIMEOUT;
                timeout  <= 1'b1;
                buzz_req <= 1'b1;
              end
            end
          end
          default: ;  // LOCKED and TIMEOUT hold until clear
        endcase
      end
    end
  end

endmodule

// File: tb/tb_answer_arbiter.sv
// Directed bench for answer_arbiter with DEBOUNCE_CYCLES=4 (press to lock = 7 clocks).
module tb_answer_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] press;
  logic [3:0] players_en;
  logic       arm;
  logic       clear;
  logic       sec_tick;
  logic [5:0] time_limit;
  logic       winner_valid;
  logic [1:0] winner_id;
  logic [3:0] winner_onehot;
  logic       timeout;
  logic [5:0] remaining;
  logic [3:0] false_start;
  logic       buzz_req;

  int tests_run = 0;
  int tests_failed = 0;
  int buzz_cnt = 0;

  answer_arbiter #(.N_PLAYERS(4), .DEBOUNCE_CYCLES(4), .TIME_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .press         (press),
    .players_en    (players_en),
    .arm           (arm),
    .clear         (clear),
    .sec_tick      (sec_tick),
    .time_limit    (time_limit),
    .winner_valid  (winner_valid),
    .winner_id     (winner_id),
    .winner_onehot (winner_onehot),
    .timeout       (timeout),
    .remaining     (remaining),
    .false_start   (false_start),
    .buzz_req      (buzz_req)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (buzz_req) buzz_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm(input logic [5:0] tl);
    time_limit = tl;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic pulse_sec();
    sec_tick = 1'b1;
    tick(1);
    sec_tick = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_wv"}, winner_valid, 0);
    check({tag, "_oh"}, winner_onehot, 0);
    check({tag, "_to"}, timeout, 0);
    check({tag, "_rem"}, remaining, 0);
    check({tag, "_fs"}, false_start, 0);
  endtask

  initial begin
    rst = 1'b1; press = '0; players_en = 4'b1111; arm = 0; clear = 0;
    sec_tick = 0; time_limit = '0;
    tick(2);
    rst = 1'b0;
    check_idle("reset");
    check("reset_buzz", buzz_req, 0);

    // 1: single player holds button
    pulse_arm(6'd10);
    buzz_cnt = 0;
    press[2] = 1'b1;
    tick(6);
    check("t1_not_yet", winner_valid, 0);
    tick(1);
    check("t1_wv", winner_valid, 1);
    check("t1_id", winner_id, 2);
    check("t1_oh", winner_onehot, 4'b0100);
    check("t1_rem", remaining, 10);
    tick(3);
    press = '0;
    tick(8);
    check("t1_buzz_cnt", buzz_cnt, 1);
    pulse_clear();

    // 2: simultaneous press, lowest index wins; clear resets
    pulse_arm(6'd10);
    press = 4'b1010;
    tick(7);
    check("t2_id", winner_id, 1);
    check("t2_oh", winner_onehot, 4'b0010);
    press = '0;
    tick(8);
    pulse_clear();
    check_idle("t2_clear");

    // 3: bouncing input never settles
    pulse_arm(6'd10);
    for (int i = 0; i < 6; i++) begin
      press[0] = (i % 2 == 0);
      tick(2);
    end
    press = '0;
    tick(10);
    check("t3_wv", winner_valid, 0);
    check("t3_rem", remaining, 10);
    pulse_clear();

    // 4: false start locks a player out for the round
    press[3] = 1'b1;
    tick(7);
    check("t4_fs", false_start, 4'b1000);
    press[3] = 1'b0;
    tick(8);
    pulse_arm(6'd10);
    press[3] = 1'b1;
    tick(3);
    press[0] = 1'b1;
    tick(6);
    check("t4_p3_ignored", winner_valid, 0);
    tick(1);
    check("t4_wv", winner_valid, 1);
    check("t4_id", winner_id, 0);
    check("t4_fs_kept", false_start, 4'b1000);
    press = '0;
    tick(8);
    pulse_clear();
    players_en = 4'b0111;
    press[3] = 1'b1;
    tick(8);
    check("t4_fs_disabled", false_start, 0);
    press = '0;
    tick(8);
    players_en = 4'b1111;

    // 5: countdown to timeout
    pulse_arm(6'd3);
    check("t5_rem3", remaining, 3);
    buzz_cnt = 0;
    pulse_sec();
    check("t5_rem2", remaining, 2);
    pulse_sec();
    check("t5_rem1", remaining, 1);
    check("t5_to_early", timeout, 0);
    pulse_sec();
    check("t5_rem0", remaining, 0);
    check("t5_to", timeout, 1);
    tick(2);
    check("t5_buzz_cnt", buzz_cnt, 1);
    press[1] = 1'b1;
    tick(8);
    check("t5_late_press", winner_valid, 0);
    check("t5_to_hold", timeout, 1);
    press = '0;
    tick(8);
    pulse_clear();
    pulse_arm(6'd0);
    check("t5_zero_to", timeout, 1);
    pulse_clear();

    // 6: reset mid-round, clear beats arm, edge on final tick
    pulse_arm(6'd5);
    check("t6_rem5", remaining, 5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_idle("t6_rst");
    time_limit = 6'd7;
    arm = 1'b1; clear = 1'b1;
    tick(1);
    arm = 1'b0; clear = 1'b0;
    check("t6_clear_arm_rem", remaining, 0);
    tick(1);
    check("t6_clear_arm_to", timeout, 0);
    pulse_arm(6'd1);
    press[2] = 1'b1;
    tick(6);
    sec_tick = 1'b1;
    tick(1);
    sec_tick = 1'b0;
    check("t6_final_wv", winner_valid, 1);
    check("t6_final_id", winner_id, 2);
    check("t6_final_rem", remaining, 1);
    check("t6_final_to", timeout, 0);
    press = '0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
